register_forward_buffer: RTL

Parametrised pending-write buffer between the write-back stage and the register file, holding the last DEPTH results not yet committed. Each read port looks up the youngest pending write to the same register and forwards its data. The oldest entry commits to the register file as it shifts out. Covers both the integer and float register files via a per-entry float tag.

---
 rtl/register_forward_buffer.sv | 97 +++++++++
 1 files changed

// File: rtl/register_forward_buffer.sv
// Pending-write buffer between write-back and the register file: forwards the youngest
// uncommitted write per read port and commits the oldest entry as it shifts out.
module register_forward_buffer #(
    parameter int DEPTH      = 3,
    parameter int READ_PORTS = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int POS_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             stall,
    input  logic                             flush,
    input  logic                             push,
    input  logic [ADDR_WIDTH-1:0]            push_addr,
    input  logic                             push_float,
    input  logic [DATA_WIDTH-1:0]            push_data,
    input  logic [READ_PORTS*ADDR_WIDTH-1:0] read_addr,
    input  logic [READ_PORTS-1:0]            read_float,
    output logic [READ_PORTS-1:0]            hit,
    output logic [READ_PORTS*DATA_WIDTH-1:0] hit_data,
    output logic [READ_PORTS*POS_WIDTH-1:0]  position,
    output logic                             commit_valid,
    output logic [ADDR_WIDTH-1:0]            commit_addr,
    output logic                             commit_float,
    output logic [DATA_WIDTH-1:0]            commit_data
);

    // Entry DEPTH-1 is the youngest write, entry 0 the oldest (next to commit).
    logic [DEPTH-1:0]                 r_valid;
    logic [DEPTH-1:0][ADDR_WIDTH-1:0] r_addr;
    logic [DEPTH-1:0]                 r_float;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] r_data;

    logic w_push_eff;

    // Integer r0 is hardwired to zero, so writes to it never enter the buffer.
    assign w_push_eff = push && !(!push_float && (push_addr == '0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
            r_addr  <= '0;
            r_float <= '0;
            r_data  <= '0;
        end else if (flush) begin
            r_valid <= '0;
        end else if (!stall) begin
            for (int k = 0; k < DEPTH - 1; k++) begin
                r_valid[k] <= r_valid[k+1];
                r_addr[k]  <= r_addr[k+1];
                r_float[k] <= r_float[k+1];
                r_data[k]  <= r_data[k+1];
            end
            r_valid[DEPTH-1] <= w_push_eff;
            r_addr[DEPTH-1]  <= push_addr;
            r_float[DEPTH-1] <= push_float;
            r_data[DEPTH-1]  <= push_data;
        end
    end

    assign commit_valid = r_valid[0] && !stall;
    assign commit_addr  = r_valid[0] ? r_addr[0]  : '0;
    assign commit_float = r_valid[0] ? r_float[0] : 1'b0;
    assign commit_data  = r_valid[0] ? r_data[0]  : '0;

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
        logic [ADDR_WIDTH-1:0] w_raddr;
        logic                  w_rfloat;
        logic                  w_hit;
        logic [POS_WIDTH-1:0]  w_pos;
        logic [DATA_WIDTH-1:0] w_data;

        assign w_raddr  = read_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_rfloat = read_float[p];

        // Ascending scan so the highest (youngest) matching entry overrides older ones.
        always_comb begin
            w_hit  = 1'b0;
            w_pos  = POS_WIDTH'(DEPTH);
            w_data = '0;
            for (int k = 0; k < DEPTH; k++) begin
                if (r_valid[k] && (r_addr[k] == w_raddr) && (r_float[k] == w_rfloat)
                    && !(!w_rfloat && (w_raddr == '0))) begin
                    w_hit  = 1'b1;
                    w_pos  = POS_WIDTH'(k);
                    w_data = r_data[k];
                end
            end
        end

        assign hit[p]                              = w_hit;
        assign position[p*POS_WIDTH +: POS_WIDTH]  = w_pos;
        assign hit_data[p*DATA_WIDTH +: DATA_WIDTH] = w_data;
    end

endmodule
